// File: rtl/fp_normalize_pipe.sv
// Two-stage normalisation for the FP add/sub datapath: stage 1 registers the operands and their
// leading-zero count, stage 2 registers the normalised result. Optional macro: NORM_INF_SAT_EN.
module fp_normalize_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] pre_E,
    input  logic [MAN_W:0]   pre_M,
    input  logic             OV,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] E,
    output logic [MAN_W-1:0] M,
    output logic             NaN,
    output logic             zero,
    output logic             inf
);

    localparam int LZ_W = $clog2(MAN_W + 2);
    localparam int CW   = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 1;
    localparam logic [EXP_W-1:0] E_ONES = '1;

    function automatic logic [LZ_W-1:0] lead_zeros(input logic [MAN_W:0] v);
        lead_zeros = LZ_W'(MAN_W + 1);
        for (int i = 0; i <= MAN_W; i++) begin
            if (v[i]) lead_zeros = LZ_W'(MAN_W - i);
        end
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [EXP_W-1:0] s1_e_q, s1_e_d;
    logic [MAN_W:0]   s1_m_q, s1_m_d;
    logic             s1_ov_q, s1_ov_d;
    logic             s1_op_q, s1_op_d;
    logic [LZ_W-1:0]  s1_lz_q, s1_lz_d;

    logic             s2_valid_q, s2_valid_d;
    logic [EXP_W-1:0] e_q, e_d;
    logic [MAN_W-1:0] m_q, m_d;
    logic             nan_q, nan_d;
    logic             zero_q, zero_d;
    logic             inf_q, inf_d;

    logic             s2_free, s1_load, s2_load;
    logic [EXP_W:0]   sum;
    logic             carry;
    logic [CW-1:0]    e_ext, lz_ext;
    logic [EXP_W-1:0] res_e;
    logic [MAN_W-1:0] res_m;
    logic             res_nan, res_zero, res_inf;
`ifdef NORM_INF_SAT_EN
    logic             ovf;
`endif

    // Stage 1 boundary: operand capture and leading-zero count
    always_comb begin
        s2_free    = !s2_valid_q | out_ready;
        in_ready   = !s1_valid_q | s2_free;
        s1_load    = in_valid & in_ready;
        s2_load    = s1_valid_q & s2_free;
        s1_valid_d = s1_load | (s1_valid_q & !s2_free);
        s2_valid_d = s2_free ? s1_valid_q : s2_valid_q;
        s1_e_d     = s1_load ? pre_E : s1_e_q;
        s1_m_d     = s1_load ? pre_M : s1_m_q;
        s1_ov_d    = s1_load ? OV : s1_ov_q;
        s1_op_d    = s1_load ? op : s1_op_q;
        s1_lz_d    = s1_load ? lead_zeros(pre_M) : s1_lz_q;
    end

    // Stage 2 boundary: normalise, classify, and register the result
    always_comb begin
        sum      = {1'b0, s1_e_q} + {{EXP_W{1'b0}}, 1'b1};
        e_ext    = CW'(s1_e_q);
        lz_ext   = CW'(s1_lz_q);
        carry    = 1'b0;
        res_zero = 1'b0;
        res_inf  = 1'b0;
        if (!s1_op_q) begin
            if (s1_ov_q) begin
                carry = sum[EXP_W];
                res_e = sum[EXP_W-1:0];
                res_m = s1_m_q[MAN_W:1];
            end else begin
                res_e = s1_e_q;
                res_m = s1_m_q[MAN_W-1:0];
            end
        end else if (s1_m_q == '0 || lz_ext > e_ext) begin
            // exact cancellation or exponent would go negative: flush to zero
            res_zero = 1'b1;
            res_e    = '0;
            res_m    = '0;
        end else begin
            res_e = EXP_W'(e_ext - lz_ext);
            res_m = MAN_W'(s1_m_q << s1_lz_q);
        end
`ifdef NORM_INF_SAT_EN
        ovf     = carry | (!s1_op_q & (res_e == E_ONES));
        res_nan = !ovf & (s1_e_q == E_ONES) & (s1_m_q != '0);
        if (ovf) begin
            res_e   = E_ONES;
            res_m   = '0;
            res_inf = 1'b1;
        end
`else
        res_nan = carry | ((res_e == E_ONES) && (res_m != '0));
`endif
        e_d    = s2_load ? res_e : e_q;
        m_d    = s2_load ? res_m : m_q;
        nan_d  = s2_load ? res_nan : nan_q;
        zero_d = s2_load ? res_zero : zero_q;
        inf_d  = s2_load ? res_inf : inf_q;
    end

    always_ff @(posedge clk) begin
        s1_e_q  <= s1_e_d;
        s1_m_q  <= s1_m_d;
        s1_ov_q <= s1_ov_d;
        s1_op_q <= s1_op_d;
        s1_lz_q <= s1_lz_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            e_q        <= '0;
            m_q        <= '0;
            nan_q      <= 1'b0;
            zero_q     <= 1'b0;
            inf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            e_q        <= e_d;
            m_q        <= m_d;
            nan_q      <= nan_d;
            zero_q     <= zero_d;
            inf_q      <= inf_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign E         = e_q;
    assign M         = m_q;
    assign NaN       = nan_q;
    assign zero      = zero_q;
    assign inf       = inf_q;

endmodule
